fb_swap_controller: RTL
=======================

# fb_swap_controller

Schedules framebuffer flips between the rasterizer and the DVI scan-out so that a flip only ever takes effect at a frame boundary. It owns the display base address fed to the DVI framebuffer reader and the render base address fed to the rasterizer. It replaces the unsynchronised toggle in the display wrapper. It sits in the display clock domain, between the rasterizer swap handshake and the DVI core's read-address offset.

## Interface
Parameters:
- FB_1_ADDR, 32'h01E00000, buffer 0 base address.
- FB_2_ADDR, 32'h01C00000, buffer 1 base address.
- FB_3_ADDR, 32'h01A00000, buffer 2 base address; used only with triple buffering.

Ports:
- aclk  in  1  clock; one clock for the whole block, all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- swap  in  1  rasterizer flip request (level signal).
- swapped  out  1  handshake ready/complete (level signal).
- frame_start  in  1  single-cycle pulse from scan-out, issued at the start of vertical blank before the first fetch of the next frame.
- disp_addr  out  32  base address for the DVI read path.
- render_addr  out  32  base address the rasterizer writes to.
- frame_cnt  out  16  count of frame_start pulses; wraps at 0xFFFF→0.
- flip_pending  out  1  a flip is queued and waiting for frame_start.

## Operation
- Buffers are tracked as 2-bit indices (disp_idx, rend_idx, and queue_idx in triple mode). Addresses are muxed from the indices.
- Reset values: disp_idx=0, rend_idx=1, swapped=1, flip_pending=0, frame_cnt=0, drop_cnt=0.
- Handshake:
  - swapped=1 means a request can be accepted.
  - The rasterizer raises swap. The block drops swapped when it accepts the request.
  - swapped returns to 1 only after the flip is committed and swap is low.
  - The rasterizer must not write render_addr while swapped=0.
- Double-buffer FSM:
  - IDLE: when swap && swapped, go to PEND; swapped←0, flip_pending←1.
  - PEND: on frame_start, go to DONE; swap disp_idx and rend_idx; flip_pending←0.
  - DONE: when !swap, go to IDLE; swapped←1.
  - If swap drops while in PEND, the flip still commits. The next transition is then PEND→DONE→IDLE on consecutive cycles.
- Simultaneous events:
  - swap accepted in the same cycle as frame_start: the flip commits at the next frame_start, never the current one.
  - frame_start in IDLE or DONE: only frame_cnt increments.
- Reset mid-operation: any state returns to reset values immediately (async). A pending flip is discarded.

## Timing
- disp_addr and render_addr are registered and change exactly 1 cycle after the committing frame_start edge.
- swapped falls 1 cycle after swap is sampled high in IDLE.
- Minimum handshake latency is 3 cycles when frame_start arrives right after acceptance and swap has already dropped. Maximum latency is one frame plus 2 cycles.
- frame_cnt updates 1 cycle after each frame_start.
- All outputs are glitch-free registers. There is no combinational path from input to output.

## Configuration
- FB_TRIPLE_BUFFER_EN defined:
  - Three buffers with queue_idx and a queue_valid flag.
  - On accept: if the queue is empty, queue←rend and rend←free index. If the queue is full, swap queue and rend (the older queued frame is dropped) and drop_cnt increments.
  - swapped returns to 1 one cycle after swap goes low, without waiting for frame_start.
  - On frame_start with queue_valid: disp←queue, the old disp becomes the free index, queue_valid←0.
  - flip_pending mirrors queue_valid.
  - Adds output drop_cnt [15:0] (saturating at 0xFFFF).
- FB_TRIPLE_BUFFER_EN undefined: double-buffer FSM only, FB_3_ADDR is ignored, and drop_cnt is absent.

## Structure
- Shared package fb_pkg:
  - buffer index typedef (2 bits).
  - FSM state enum (IDLE, PEND, DONE).
  - constant NUM_FB (2 or 3, selected by the macro).
- One natural sub-module, fb_buf_allocator. It computes the free index and the next queue/render/display indices combinationally from the current indices. It is instantiated only in triple mode.

## Test plan
- Reset, then read outputs → disp_addr=01E00000, render_addr=01C00000, swapped=1, frame_cnt=0.
- swap high at cycle 10, frame_start at cycle 50, swap low at cycle 20 → swapped=0 at cycle 11. disp_addr=01C00000 and render_addr=01E00000 at cycle 51. swapped=1 at cycle 52.
- swap accepted in the same cycle as frame_start → no flip at that pulse. Flip occurs on the following frame_start pulse.
- 0x10000 frame_start pulses with no swap → frame_cnt wraps to 0. disp_addr is unchanged.
- resetn pulsed low while in PEND → all outputs return to reset values. A later frame_start causes no flip.
- Triple mode: two completed swaps before any frame_start → drop_cnt=1. After frame_start, disp_addr is the most recently queued buffer, and render_addr never equals disp_addr.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer swap controller.
// Build option: FB_TRIPLE_BUFFER_EN selects three buffers instead of two.
package fb_pkg;

`ifdef FB_TRIPLE_BUFFER_EN
    localparam int NUM_FB = 3;
`else
    localparam int NUM_FB = 2;
`endif

    // Buffer index: 0, 1 or 2.
    typedef logic [1:0] fb_idx_t;

    // Handshake FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } fb_state_t;

    // With three buffers the indices always form {0,1,2}, so the one not in
    // use is 3 minus the other two.
    function automatic fb_idx_t free_idx(input fb_idx_t a, input fb_idx_t b);
        return fb_idx_t'(2'd3 - a - b);
    endfunction

endpackage

// File: rtl/fb_buf_allocator.sv
// Next-index computation for triple buffering (display / render / queue).
// Build option: FB_TRIPLE_BUFFER_EN; the module only exists in triple builds.
`ifdef FB_TRIPLE_BUFFER_EN
module fb_buf_allocator
    import fb_pkg::*;
(
    input  fb_idx_t disp_idx,
    input  fb_idx_t rend_idx,
    input  fb_idx_t queue_idx,
    input  logic    queue_valid,
    input  logic    frame_start,
    input  logic    accept,
    output fb_idx_t disp_idx_next,
    output fb_idx_t rend_idx_next,
    output fb_idx_t queue_idx_next,
    output logic    queue_valid_next,
    output logic    drop
);

    fb_idx_t disp_flip;
    logic    valid_flip;

    // A frame boundary consumes the queued frame first; a request accepted
    // in the same cycle is then queued behind it and waits for the next one.
    always_comb begin
        disp_flip  = disp_idx;
        valid_flip = queue_valid;
        if (frame_start && queue_valid) begin
            disp_flip  = queue_idx;
            valid_flip = 1'b0;
        end

        disp_idx_next    = disp_flip;
        rend_idx_next    = rend_idx;
        queue_idx_next   = queue_idx;
        queue_valid_next = valid_flip;
        drop             = 1'b0;

        if (accept) begin
            queue_idx_next   = rend_idx;
            queue_valid_next = 1'b1;
            if (valid_flip) begin
                // Older queued frame is overwritten: render into its buffer.
                rend_idx_next = queue_idx;
                drop          = 1'b1;
            end else begin
                rend_idx_next = free_idx(disp_flip, rend_idx);
            end
        end
    end

endmodule
`endif

// File: rtl/fb_swap_controller.sv
// Framebuffer flip scheduler: flips only take effect on frame_start.
// Build option: FB_TRIPLE_BUFFER_EN enables triple buffering and drop_cnt.
module fb_swap_controller
    import fb_pkg::*;
#(
    parameter logic [31:0] FB_1_ADDR = 32'h01E00000,
    parameter logic [31:0] FB_2_ADDR = 32'h01C00000,
    parameter logic [31:0] FB_3_ADDR = 32'h01A00000
)
(
    input  logic        aclk,
    input  logic        resetn,
    input  logic        swap,
    output logic        swapped,
    input  logic        frame_start,
    output logic [31:0] disp_addr,
    output logic [31:0] render_addr,
    output logic [15:0] frame_cnt,
    output logic        flip_pending
`ifdef FB_TRIPLE_BUFFER_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    fb_state_t   state_reg, state_next;
    logic        swapped_reg, swapped_next;
    fb_idx_t     disp_idx_reg, disp_idx_next;
    fb_idx_t     rend_idx_reg, rend_idx_next;
    logic [31:0] disp_addr_reg, render_addr_reg;
    logic [15:0] frame_cnt_reg;
    logic [31:0] fb_addr_tbl [4];
    logic        accept;

    // Index-to-address table; unused indices alias buffer 0.
    for (genvar gi = 0; gi < 4; gi++) begin : g_addr_tbl
        assign fb_addr_tbl[gi] = (gi == 0) ? FB_1_ADDR :
                                 (gi == 1) ? FB_2_ADDR :
                                 (gi == 2 && NUM_FB == 3) ? FB_3_ADDR : FB_1_ADDR;
    end

    assign accept = (state_reg == IDLE) && swap && swapped_reg;

`ifdef FB_TRIPLE_BUFFER_EN
    fb_idx_t     queue_idx_reg, queue_idx_next;
    logic        queue_valid_reg, queue_valid_next;
    logic        drop;
    logic [15:0] drop_cnt_reg;

    fb_buf_allocator u_alloc (
        .disp_idx         (disp_idx_reg),
        .rend_idx         (rend_idx_reg),
        .queue_idx        (queue_idx_reg),
        .queue_valid      (queue_valid_reg),
        .frame_start      (frame_start),
        .accept           (accept),
        .disp_idx_next    (disp_idx_next),
        .rend_idx_next    (rend_idx_next),
        .queue_idx_next   (queue_idx_next),
        .queue_valid_next (queue_valid_next),
        .drop             (drop)
    );

    // Queue slot and saturating dropped-frame counter.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            queue_idx_reg   <= 2'd2;
            queue_valid_reg <= 1'b0;
            drop_cnt_reg    <= 16'd0;
        end else begin
            queue_idx_reg   <= queue_idx_next;
            queue_valid_reg <= queue_valid_next;
            if (drop && drop_cnt_reg != 16'hFFFF)
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign flip_pending = queue_valid_reg;
    assign drop_cnt     = drop_cnt_reg;
`else
    logic flip_pending_reg, flip_pending_next;

    // Pending-flip flag for the double-buffer handshake.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn)
            flip_pending_reg <= 1'b0;
        else
            flip_pending_reg <= flip_pending_next;
    end

    assign flip_pending = flip_pending_reg;
`endif

    // Handshake FSM next-state and index updates.
    always_comb begin
        state_next   = state_reg;
        swapped_next = swapped_reg;
`ifndef FB_TRIPLE_BUFFER_EN
        disp_idx_next     = disp_idx_reg;
        rend_idx_next     = rend_idx_reg;
        flip_pending_next = flip_pending_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    swapped_next = 1'b0;
`ifdef FB_TRIPLE_BUFFER_EN
                    // Queued immediately; only wait for swap to drop.
                    state_next = DONE;
`else
                    state_next        = PEND;
                    flip_pending_next = 1'b1;
`endif
                end
            end
            PEND: begin
`ifdef FB_TRIPLE_BUFFER_EN
                state_next = IDLE;
`else
                if (frame_start) begin
                    state_next        = DONE;
                    disp_idx_next     = rend_idx_reg;
                    rend_idx_next     = disp_idx_reg;
                    flip_pending_next = 1'b0;
                end
`endif
            end
            DONE: begin
                if (!swap) begin
                    state_next   = IDLE;
                    swapped_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, indices, registered addresses and frame counter.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            swapped_reg     <= 1'b1;
            disp_idx_reg    <= 2'd0;
            rend_idx_reg    <= 2'd1;
            disp_addr_reg   <= FB_1_ADDR;
            render_addr_reg <= FB_2_ADDR;
            frame_cnt_reg   <= 16'd0;
        end else begin
            state_reg       <= state_next;
            swapped_reg     <= swapped_next;
            disp_idx_reg    <= disp_idx_next;
            rend_idx_reg    <= rend_idx_next;
            disp_addr_reg   <= fb_addr_tbl[disp_idx_next];
            render_addr_reg <= fb_addr_tbl[rend_idx_next];
            if (frame_start)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign swapped     = swapped_reg;
    assign disp_addr   = disp_addr_reg;
    assign render_addr = render_addr_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule
